// File: rtl/palette_mapper.sv
// DMG palette mapper: resolves BG/OBJ colour indices to shades on a 2-stage valid/ready pipe.
// Define PAL_LINE_LATCH_EN to latch palettes once per scanline instead of per pixel.
module palette_mapper #(
  parameter int LINE_PIXELS = 160,
  parameter int X_W         = 8
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic [7:0]     bgp_d,
  input  logic [7:0]     obp0_d,
  input  logic [7:0]     obp1_d,
  input  logic           bg_en,
  input  logic           obj_en,
  input  logic           line_start,
  input  logic           pix_valid,
  output logic           pix_ready,
  input  logic [1:0]     pix_bg_idx,
  input  logic [1:0]     pix_obj_idx,
  input  logic           pix_obj_pal,
  input  logic           pix_obj_prio,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     out_shade,
  output logic [X_W-1:0] out_x,
  output logic           line_done
);

  logic           advance;
  logic           s1_valid;
  logic [1:0]     s1_bg;
  logic [1:0]     s1_obj;
  logic           s1_pal;
  logic           s1_prio;
  logic           s1_bg_en;
  logic           s1_obj_en;
  logic [7:0]     s1_bgp;
  logic [7:0]     s1_obp0;
  logic [7:0]     s1_obp1;
  logic [7:0]     src_bgp;
  logic [7:0]     src_obp0;
  logic [7:0]     src_obp1;
  logic [1:0]     bg_eff;
  logic           opaque;
  logic           obj_wins;
  logic [7:0]     obj_pal;
  logic [1:0]     shade;
  logic [X_W-1:0] x_cnt;
  logic           x_last;
  logic           take_out;

`ifdef PAL_LINE_LATCH_EN
  logic [7:0] sh_bgp;
  logic [7:0] sh_obp0;
  logic [7:0] sh_obp1;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sh_bgp  <= '0;
      sh_obp0 <= '0;
      sh_obp1 <= '0;
    end else if (line_start) begin
      sh_bgp  <= bgp_d;
      sh_obp0 <= obp0_d;
      sh_obp1 <= obp1_d;
    end
  end

  // First pixel of a line sees the palette being latched that same cycle
  assign src_bgp  = line_start ? bgp_d  : sh_bgp;
  assign src_obp0 = line_start ? obp0_d : sh_obp0;
  assign src_obp1 = line_start ? obp1_d : sh_obp1;
`else
  assign src_bgp  = bgp_d;
  assign src_obp0 = obp0_d;
  assign src_obp1 = obp1_d;
`endif

  assign advance   = !out_valid | out_ready;
  // A flush empties S1, so a pixel alongside line_start always enters
  assign pix_ready = line_start | !s1_valid | advance;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_valid  <= 1'b0;
      s1_bg     <= '0;
      s1_obj    <= '0;
      s1_pal    <= 1'b0;
      s1_prio   <= 1'b0;
      s1_bg_en  <= 1'b0;
      s1_obj_en <= 1'b0;
      s1_bgp    <= '0;
      s1_obp0   <= '0;
      s1_obp1   <= '0;
    end else if (pix_ready) begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_bg     <= pix_bg_idx;
        s1_obj    <= pix_obj_idx;
        s1_pal    <= pix_obj_pal;
        s1_prio   <= pix_obj_prio;
        s1_bg_en  <= bg_en;
        s1_obj_en <= obj_en;
        s1_bgp    <= src_bgp;
        s1_obp0   <= src_obp0;
        s1_obp1   <= src_obp1;
      end
    end
  end

  assign bg_eff   = s1_bg_en ? s1_bg : 2'd0;
  assign opaque   = s1_obj_en & (s1_obj != 2'd0);
  assign obj_wins = opaque & (!s1_prio | (bg_eff == 2'd0));
  assign obj_pal  = s1_pal ? s1_obp1 : s1_obp0;
  assign shade    = obj_wins ? obj_pal[{s1_obj, 1'b0} +: 2]
                             : s1_bgp[{bg_eff, 1'b0} +: 2];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_shade <= '0;
    end else if (line_start) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) out_shade <= shade;
    end
  end

  assign take_out = out_valid & out_ready;
  assign x_last   = (x_cnt == X_W'(LINE_PIXELS - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      x_cnt <= '0;
    end else if (line_start) begin
      x_cnt <= '0;
    end else if (take_out) begin
      x_cnt <= x_last ? '0 : x_cnt + 1'b1;
    end
  end

  assign out_x     = x_cnt;
  assign line_done = take_out & x_last & !line_start;

endmodule
